// File: rtl/seq_alu_pkg.sv
// Shared core definitions for the sequential ALU: operation codes and FSM states.
package seq_alu_pkg;

  localparam logic [4:0] ALU_OP_ADD   = 5'b00000;
  localparam logic [4:0] ALU_OP_SUB   = 5'b00001;
  localparam logic [4:0] ALU_OP_AND   = 5'b00010;
  localparam logic [4:0] ALU_OP_OR    = 5'b00011;
  localparam logic [4:0] ALU_OP_XOR   = 5'b00100;
  localparam logic [4:0] ALU_OP_SLL   = 5'b00101;
  localparam logic [4:0] ALU_OP_SRL   = 5'b00110;
  localparam logic [4:0] ALU_OP_SRA   = 5'b00111;
  localparam logic [4:0] ALU_OP_SLT   = 5'b01000;
  localparam logic [4:0] ALU_OP_SLTU  = 5'b01001;
  localparam logic [4:0] ALU_OP_PASSB = 5'b01010;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  function automatic logic is_shift(input logic [4:0] op);
    return (op == ALU_OP_SLL) || (op == ALU_OP_SRL) || (op == ALU_OP_SRA);
  endfunction

endpackage

// File: rtl/seq_alu_alu_comb.sv
// Single-cycle combinational ALU datapath; illegal codes produce zero.
module alu_comb
  import seq_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      aluControl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  logic [4:0] shamt;
  logic       lt_signed;
  logic       lt_unsigned;

  assign shamt       = b[4:0];
  assign lt_signed   = $signed(a) < $signed(b);
  assign lt_unsigned = a < b;

  always_comb begin
    y = '0;
    case (aluControl)
      ALU_OP_ADD:   y = a + b;
      ALU_OP_SUB:   y = a - b;
      ALU_OP_AND:   y = a & b;
      ALU_OP_OR:    y = a | b;
      ALU_OP_XOR:   y = a ^ b;
      ALU_OP_SLL:   y = a << shamt;
      ALU_OP_SRL:   y = a >> shamt;
      ALU_OP_SRA:   y = $unsigned($signed(a) >>> shamt);
      ALU_OP_SLT:   y = {{(XLEN-1){1'b0}}, lt_signed};
      ALU_OP_SLTU:  y = {{(XLEN-1){1'b0}}, lt_unsigned};
      ALU_OP_PASSB: y = b;
      default:      y = '0;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: valid/ready handshake, one-bit-per-cycle shifter for nonzero
// shift amounts, everything else completes through alu_comb in one cycle.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inValid,
  output logic            inReady,
  input  logic [4:0]      aluControl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            outValid,
  input  logic            outReady,
  output logic [XLEN-1:0] result
);

  state_t          state;
  logic [4:0]      count;
  logic [4:0]      op;
  logic [XLEN-1:0] work;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] alu_y;

  alu_comb #(.XLEN(XLEN)) u_alu (
    .aluControl(aluControl),
    .a         (a),
    .b         (b),
    .y         (alu_y)
  );

  assign inReady = (state == IDLE);

  always_comb begin
    shifted = work >> 1;
    case (op)
      ALU_OP_SLL: shifted = work << 1;
      ALU_OP_SRA: shifted = {work[XLEN-1], work[XLEN-1:1]};
      default:    shifted = work >> 1;
    endcase
  end

  // Zero shift amounts take the single-cycle path, where alu_comb yields a.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      op       <= '0;
      work     <= '0;
      result   <= '0;
      outValid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (inValid) begin
            op <= aluControl;
            if (is_shift(aluControl) && (b[4:0] != 5'd0)) begin
              state <= SHIFT;
              work  <= a;
              count <= b[4:0];
            end else begin
              state    <= DONE;
              result   <= alu_y;
              outValid <= 1'b1;
            end
          end
        end
        SHIFT: begin
          work  <= shifted;
          count <= count - 5'd1;
          if (count == 5'd1) begin
            state    <= DONE;
            result   <= shifted;
            outValid <= 1'b1;
          end
        end
        DONE: begin
          if (outReady) begin
            state    <= IDLE;
            outValid <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          outValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu with hand-computed expected values.
module tb_seq_alu;

  logic        clk;
  logic        rst_n;
  logic        inValid;
  logic        inReady;
  logic [4:0]  aluControl;
  logic [31:0] a;
  logic [31:0] b;
  logic        outValid;
  logic        outReady;
  logic [31:0] result;

  int tests_run = 0;
  int tests_failed = 0;

  seq_alu #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inValid   (inValid),
    .inReady   (inReady),
    .aluControl(aluControl),
    .a         (a),
    .b         (b),
    .outValid  (outValid),
    .outReady  (outReady),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Offers one op, waits for outValid, returns result and accept-to-valid latency.
  task automatic apply_stimulus(input logic [4:0] op, input logic [31:0] op_a, input logic [31:0] op_b,
                                output logic [31:0] res, output int lat);
    aluControl = op;
    a          = op_a;
    b          = op_b;
    inValid    = 1'b1;
    outReady   = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    a       = 32'hDEAD_BEEF;
    b       = 32'hDEAD_BEEF;
    lat     = 1;
    while (!outValid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = result;
    @(posedge clk);
    #1;
    check_output({"ready_after_", $sformatf("%02h", op)}, {31'b0, inReady}, 32'd1);
  endtask

  task automatic run_check(input string tag, input logic [4:0] op, input logic [31:0] op_a,
                           input logic [31:0] op_b, input logic [31:0] exp_res, input int exp_lat);
    logic [31:0] res;
    int          lat;
    apply_stimulus(op, op_a, op_b, res, lat);
    check_output({tag, "_result"}, res, exp_res);
    check_output({tag, "_latency"}, lat, exp_lat);
  endtask

  initial begin
    logic [31:0] held;
    bit          seen_valid;

    rst_n      = 1'b0;
    inValid    = 1'b0;
    outReady   = 1'b0;
    aluControl = 5'd0;
    a          = '0;
    b          = '0;
    #23;
    check_output("reset_outValid", {31'b0, outValid}, 32'd0);
    check_output("reset_result", result, 32'd0);
    rst_n = 1'b1;
    #1;
    check_output("reset_inReady", {31'b0, inReady}, 32'd1);

    run_check("add_wrap", 5'b00000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1);
    run_check("sub_wrap", 5'b00001, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1);
    run_check("and",      5'b00010, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1);
    run_check("or",       5'b00011, 32'hF000_000F, 32'h0000_F0F0, 32'hF000_F0FF, 1);
    run_check("xor",      5'b00100, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1);
    run_check("passb",    5'b01010, 32'h1234_5678, 32'hCAFE_F00D, 32'hCAFE_F00D, 1);
    run_check("sra31",    5'b00111, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 32);
    run_check("srl31",    5'b00110, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 32);
    run_check("sll0",     5'b00101, 32'h0000_0003, 32'hFFFF_FFE0, 32'h0000_0003, 1);
    run_check("sll4",     5'b00101, 32'h0000_0001, 32'h0000_0024, 32'h0000_0010, 5);
    run_check("sra3",     5'b00111, 32'h8000_00F0, 32'h0000_0003, 32'hF000_001E, 4);
    run_check("slt",      5'b01000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1);
    run_check("sltu",     5'b01001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1);
    run_check("illegal",  5'b11111, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 1);

    // Hold in DONE with outReady low while inputs churn.
    aluControl = 5'b00000;
    a          = 32'd5;
    b          = 32'd7;
    inValid    = 1'b1;
    outReady   = 1'b0;
    @(posedge clk);
    #1;
    held = 32'd12;
    for (int i = 0; i < 5; i++) begin
      inValid    = ~inValid;
      a          = a + 32'h0101_0101;
      b          = ~b;
      aluControl = 5'b00100;
      @(posedge clk);
      #1;
      check_output($sformatf("hold_result_%0d", i), result, held);
      check_output($sformatf("hold_valid_%0d", i), {31'b0, outValid}, 32'd1);
      check_output($sformatf("hold_ready_%0d", i), {31'b0, inReady}, 32'd0);
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    @(posedge clk);
    #1;
    check_output("release_inReady", {31'b0, inReady}, 32'd1);
    check_output("release_outValid", {31'b0, outValid}, 32'd0);

    // Reset in the middle of a 20-step shift discards the operation.
    aluControl = 5'b00101;
    a          = 32'h0000_0001;
    b          = 32'h0000_0014;
    inValid    = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("midshift_rst_outValid", {31'b0, outValid}, 32'd0);
    check_output("midshift_rst_result", result, 32'd0);
    #3;
    rst_n = 1'b1;
    seen_valid = 1'b0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (outValid) seen_valid = 1'b1;
    end
    check_output("midshift_no_output", {31'b0, seen_valid}, 32'd0);
    run_check("add_after_rst", 5'b00000, 32'd2, 32'd3, 32'h0000_0005, 1);

    // First accept on the first edge after reset release.
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    run_check("first_edge_accept", 5'b00011, 32'h0000_0F00, 32'h0000_00F0, 32'h0000_0FF0, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: XLEN, 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  core clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 inValid  input  1  upstream offers an operation.
REQ-005 inReady  output  1  unit can accept an operation.
REQ-006 aluControl  input  5  operation code from the ALU-control stage; sampled on accept.
REQ-007 a  input  XLEN  operand A; sampled on accept.
REQ-008 b  input  XLEN  operand B or immediate; sampled on accept.
REQ-009 outValid  output  1  result available.
REQ-010 outReady  input  1  downstream consumes the result.
REQ-011 result  output  XLEN  operation result; held stable while outValid=1.

Function
REQ-012 Codes SHALL be: ADD 00000, SUB 00001, AND 00010, OR 00011, XOR 00100, SLL 00101, SRL 00110, SRA 00111, SLT 01000, SLTU 01001, PASSB 01010; all other codes are illegal.
REQ-013 FSM states SHALL be IDLE, SHIFT, DONE.
REQ-014 inReady SHALL equal (state==IDLE); accept occurs on an edge with inValid&&inReady.
REQ-015 On accept of a non-shift legal op, the FSM SHALL go to DONE with result computed from the sampled operands (latency 1 cycle).
REQ-016 ADD/SUB SHALL wrap modulo 2^XLEN; SLT signed and SLTU unsigned SHALL give 1 or 0 zero-extended; PASSB SHALL return b.
REQ-017 On accept of SLL/SRL/SRA, shamt SHALL be b[4:0]; b[31:5] is ignored.
REQ-018 On a shift with shamt=0, the FSM SHALL go to DONE with result=a (latency 1).
REQ-019 On a shift with shamt>0, the FSM SHALL go to SHIFT, load the working register with a and the counter with shamt, then shift one bit per cycle, decrementing the counter.
REQ-020 SRA SHALL replicate bit 31 on each step; SRL/SLL SHALL fill with 0.
REQ-021 When the counter reaches 0, the FSM SHALL enter DONE; total accept-to-outValid latency SHALL be 1+shamt cycles (max 32).
REQ-022 In DONE, outValid SHALL be 1 and result held until an edge with outReady=1, after which the FSM SHALL return to IDLE.
REQ-023 Back-to-back throughput SHALL be one op per 2 cycles minimum; there is no DONE-to-accept bypass.
REQ-024 An illegal code SHALL complete like a non-shift op with result=0.
REQ-025 inValid and operand changes outside an accept edge SHALL have no effect.
REQ-026 outReady while outValid=0 SHALL be ignored.

Reset
REQ-027 Asserting rst_n low SHALL immediately force state IDLE, counter 0, working and result registers 0, outValid 0, and inReady 1 after release.
REQ-028 Reset during SHIFT or DONE SHALL discard the operation with no output produced.
REQ-029 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-030 The aluControl code macros (REQ-012) and FSM state encodings SHALL live in the shared core header, beside the existing ALU_OP_* and opcode macros.
REQ-031 The combinational single-cycle datapath SHALL be a sub-module alu_comb (aluControl, a, b -> y).
REQ-032 The seq_alu module SHALL contain only the FSM, counter, working register and handshake logic.

Verification
REQ-033 ADD a=0xFFFFFFFF b=0x00000001, outReady=1 -> outValid 1 cycle after accept, result 0x00000000.
REQ-034 SRA a=0x80000000 b=0x0000001F -> outValid exactly 32 cycles after accept, result 0xFFFFFFFF; SRL same operands -> 0x00000001.
REQ-035 SLL a=0x00000003 b=0xFFFFFFE0 (shamt 0) -> latency 1, result 0x00000003.
REQ-036 SLT a=0xFFFFFFFF b=0x00000001 -> result 1; SLTU same operands -> result 0.
REQ-037 DONE with outReady=0 for 5 cycles, operands and inValid toggling -> result and outValid stable, inReady 0; outReady=1 -> IDLE next cycle.
REQ-038 rst_n pulsed low mid-SHIFT (SLL shamt 20, cycle 7) -> outValid 0 immediately, no result delivered; a new ADD 2+3 after release -> result 0x00000005.
